motor_mux_switch_ctrl: RTL and testbench

- Sequencer that owns the select and step-enable controls of one physical motor output mux (8 logical step/dir channels onto one step/dir pin pair).
- Applies channel reassignment requests glitch-free:
  - waits for the current channel's step pulse to end;
  - gates step off and holds a guard time;
  - switches the select, then holds the dir setup time before re-enabling step.
- Sits between the host config register bank and the mux; one instance per physical output.

---
 rtl/motor_mux_switch_ctrl_if.sv | 22 ++
 rtl/motor_mux_switch_ctrl.sv | 138 +++++++++++++
 tb/tb_motor_mux_switch_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/motor_mux_switch_ctrl_if.sv
// Host-side reassignment request channel for one motor output mux.
// The host drives the request and the controller answers with ready.
interface motor_mux_switch_ctrl_if;
  logic       cfg_valid;
  logic [2:0] cfg_select;
  logic       cfg_enable;
  logic       cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_select,
    output cfg_enable,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_select,
    input  cfg_enable,
    output cfg_ready
  );
endinterface

// File: rtl/motor_mux_switch_ctrl.sv
// Glitch-free channel switch sequencer for one step/dir output mux.
// Waits for step low, guards, switches select, then holds dir setup.
module motor_mux_switch_ctrl #(
  parameter int GUARD_CYCLES = 4,
  parameter int DIR_SETUP    = 50,
  parameter int TIMEOUT      = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  motor_mux_switch_ctrl_if.slave   cfg,
  input  logic [7:0]               steps,
  input  logic                     force_off,
  input  logic                     clear_err,
  output logic [2:0]               mux_select,
  output logic                     enable_step,
  output logic                     busy,
  output logic                     switch_done,
  output logic                     timeout_err
);

  localparam int MAX_GD = (GUARD_CYCLES > DIR_SETUP) ?
                          GUARD_CYCLES : DIR_SETUP;
  localparam int MAX_C  = (MAX_GD > TIMEOUT) ? MAX_GD : TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DS_LAST = CW'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    GUARD,
    SETTLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    tgt_sel;
  logic          tgt_en;
  logic          fast_pend;
  logic          ready_q;

  assign cfg.cfg_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tgt_sel     <= '0;
      tgt_en      <= 1'b0;
      fast_pend   <= 1'b0;
      ready_q     <= 1'b1;
      mux_select  <= '0;
      enable_step <= 1'b0;
      busy        <= 1'b0;
      switch_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      if (clear_err)
        timeout_err <= 1'b0;

      unique case (state)
        IDLE: begin
          // same-channel request finishes one edge after accept
          if (fast_pend) begin
            enable_step <= tgt_en;
            switch_done <= 1'b1;
            fast_pend   <= 1'b0;
          end
          if (cfg.cfg_valid && ready_q) begin
            tgt_sel <= cfg.cfg_select;
            tgt_en  <= cfg.cfg_enable;
            if (cfg.cfg_select == mux_select) begin
              fast_pend <= 1'b1;
            end else begin
              state   <= WAIT_LOW;
              ready_q <= 1'b0;
              busy    <= 1'b1;
              cnt     <= '0;
            end
          end
        end

        WAIT_LOW: begin
          if (!steps[mux_select]) begin
            enable_step <= 1'b0;
            cnt         <= '0;
            state       <= GUARD;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            enable_step <= 1'b0;
            cnt         <= '0;
            state       <= GUARD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GUARD: begin
          if (cnt == GD_LAST) begin
            mux_select <= tgt_sel;
            cnt        <= '0;
            state      <= SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SETTLE: begin
          if (cnt == DS_LAST) begin
            enable_step <= tgt_en;
            switch_done <= 1'b1;
            ready_q     <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // emergency disable overrides any enable written above
      if (force_off) begin
        enable_step <= 1'b0;
        tgt_en      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motor_mux_switch_ctrl.sv
// Self-checking bench for motor_mux_switch_ctrl.
// Directed scenarios followed by randomized requests against a timing model.
module tb_motor_mux_switch_ctrl;

  localparam int G  = 2;
  localparam int D  = 3;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] steps;
  logic       force_off;
  logic       clear_err;
  logic [2:0] mux_select;
  logic       enable_step;
  logic       busy;
  logic       switch_done;
  logic       timeout_err;

  motor_mux_switch_ctrl_if cif ();

  motor_mux_switch_ctrl #(
    .GUARD_CYCLES (G),
    .DIR_SETUP    (D),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cif.slave),
    .steps       (steps),
    .force_off   (force_off),
    .clear_err   (clear_err),
    .mux_select  (mux_select),
    .enable_step (enable_step),
    .busy        (busy),
    .switch_done (switch_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [2:0] m_sel;
  logic       m_en;
  logic       m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] s,
                         input logic e,
                         input logic r,
                         input logic b,
                         input logic d,
                         input logic er);
    chk({tag, ".sel"},   32'(mux_select),    32'(s));
    chk({tag, ".en"},    32'(enable_step),   32'(e));
    chk({tag, ".ready"}, 32'(cif.cfg_ready), 32'(r));
    chk({tag, ".busy"},  32'(busy),          32'(b));
    chk({tag, ".done"},  32'(switch_done),   32'(d));
    chk({tag, ".err"},   32'(timeout_err),   32'(er));
  endtask

  task automatic idle_tick(input string tag, input logic clr);
    cif.cfg_valid = 1'b0;
    force_off     = 1'b0;
    clear_err     = clr;
    steps         = 8'($urandom);
    tick();
    if (clr) m_err = 1'b0;
    clear_err = 1'b0;
    chk_all(tag, m_sel, m_en, 1'b1, 1'b0, 1'b0, m_err);
  endtask

  // h: edges after accept that the current channel's step stays high
  // f_edge / r_edge: edge index of force_off / rst (-1 = none)
  task automatic run_req(input string tag,
                         input logic [2:0] sel,
                         input logic en,
                         input int h,
                         input int f_edge,
                         input int r_edge,
                         input bit rnd);
    int   x;
    int   dn;
    bit   to;
    bit   fast;
    bit   forced;
    logic old_en;
    logic exp_en;
    logic [2:0] exp_sel;

    fast   = (sel == m_sel);
    to     = (h >= TO);
    x      = to ? TO : h + 1;
    dn     = fast ? 1 : x + G + D;
    old_en = m_en;
    exp_en = m_en;

    cif.cfg_valid  = 1'b1;
    cif.cfg_select = sel;
    cif.cfg_enable = en;
    force_off      = (f_edge == 0);
    clear_err      = rnd && ($urandom_range(0, 7) == 0);
    steps          = 8'($urandom);
    steps[m_sel]   = 1'b1;
    tick();
    forced = force_off;
    if (clear_err) m_err = 1'b0;
    chk_all({tag, ".acc"}, m_sel, forced ? 1'b0 : old_en,
            fast, !fast, 1'b0, m_err);

    for (int k = 1; k <= dn; k++) begin
      cif.cfg_valid  = fast ? 1'b0 : 1'($urandom_range(0, rnd ? 1 : 0));
      cif.cfg_select = 3'($urandom);
      cif.cfg_enable = 1'($urandom);
      force_off      = (f_edge == k);
      clear_err      = rnd && ($urandom_range(0, 7) == 0);
      rst            = (k == r_edge);
      steps          = 8'($urandom);
      steps[m_sel]   = (k <= h);
      tick();
      if (rst) begin
        rst       = 1'b0;
        m_sel     = 3'd0;
        m_en      = 1'b0;
        m_err     = 1'b0;
        cif.cfg_valid = 1'b0;
        force_off = 1'b0;
        clear_err = 1'b0;
        chk_all({tag, ".rst"}, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (force_off) forced = 1'b1;
      if (!fast && to && k == x) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (forced)              exp_en = 1'b0;
      else if (!fast && k < x) exp_en = old_en;
      else if (k == dn)        exp_en = en;
      else                     exp_en = 1'b0;
      exp_sel = (!fast && k < x + G) ? m_sel : sel;
      chk_all($sformatf("%s.e%0d", tag, k), exp_sel, exp_en,
              k == dn, k < dn, k == dn, m_err);
    end

    m_sel = sel;
    m_en  = exp_en;
    cif.cfg_valid = 1'b0;
    force_off     = 1'b0;
    clear_err     = 1'b0;
    idle_tick({tag, ".post"}, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    cif.cfg_valid  = 1'b0;
    cif.cfg_select = 3'd0;
    cif.cfg_enable = 1'b0;
    steps          = 8'd0;
    force_off      = 1'b0;
    clear_err      = 1'b0;
    m_sel          = 3'd0;
    m_en           = 1'b0;
    m_err          = 1'b0;
    tick();
    tick();
    chk_all("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_tick("idle0", 1'b0);

    run_req("t1_switch", 3'd5, 1'b1, 0, -1, -1, 1'b0);
    run_req("t2_waitlow", 3'd2, 1'b1, 5, -1, -1, 1'b0);
    run_req("t3_timeout", 3'd1, 1'b1, 20, -1, -1, 1'b0);
    idle_tick("t3_sticky", 1'b0);
    idle_tick("t3_clear", 1'b1);
    run_req("t4_fast", 3'd1, 1'b0, 0, -1, -1, 1'b0);
    run_req("t5_force", 3'd3, 1'b1, 0, 5, -1, 1'b0);
    run_req("t6_rst", 3'd6, 1'b1, 0, -1, 2, 1'b1);
    idle_tick("t6_idle", 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] s;
      logic       e;
      int         h;
      int         f;
      int         r;
      s = 3'($urandom_range(0, 7));
      e = 1'($urandom);
      h = $urandom_range(0, 10);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      r = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : -1;
      run_req($sformatf("rnd%0d", i), s, e, h, f, r, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
